imem_line_buffer: RTL
=====================

IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

Interface
REQ-001 Parameter LINE_WORDS, default 4, 32-bit words per line (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 Instr_address_fIF  input  ADDR_W  byte address requested by fetch; bits [1:0] ignored.
REQ-006 FLUSH  input  1  invalidate all buffered lines.
REQ-007 Instr1_2IF  output  32  instruction word for Instr_address_fIF.
REQ-008 STALL_2IF  output  1  fetch shall hold its PC and discard Instr1_2IF.
REQ-009 Mem_req  output  1  line-fill request to backing memory.
REQ-010 Mem_addr  output  ADDR_W  line-aligned fill address.
REQ-011 Mem_ack  input  1  one beat of Mem_rdata valid this cycle.
REQ-012 Mem_rdata  input  32  fill data, beats in ascending word order.
REQ-013 Miss_count  output  16  demand misses since reset; wraps 0xFFFF->0.

Function
REQ-014 Line tag = address bits [ADDR_W-1 : log2(LINE_WORDS)+2]; word index = next log2(LINE_WORDS) bits above [1:0].
REQ-015 Hit = demand buffer valid and tag equal; combinational, same cycle: Instr1_2IF = indexed word, STALL_2IF = 0.
REQ-016 No hit: STALL_2IF = 1 and Instr1_2IF = 0 combinationally, in every state.
REQ-017 States: IDLE, FILL. IDLE with miss (and no fill in flight) -> FILL next edge; Miss_count increments on that edge.
REQ-018 FILL: Mem_req = 1 and Mem_addr = requested tag with zero low bits, both constant until final beat.
REQ-019 Each cycle with Mem_ack = 1 in FILL writes Mem_rdata to word[beat] and increments beat counter; Mem_ack outside FILL is ignored.
REQ-020 On edge accepting beat LINE_WORDS-1: tag latched, valid set, Mem_req drops, state -> IDLE; the refilled address hits the next cycle.
REQ-021 Minimum miss latency = LINE_WORDS+1 cycles with Mem_ack held high.
REQ-022 Instr_address_fIF changes during FILL are ignored; the in-flight fill completes, then lookup re-evaluates.
REQ-023 FLUSH in IDLE clears all valid bits on that edge.
REQ-024 FLUSH during FILL: the burst completes, but the line is not marked valid on completion.
REQ-025 FLUSH and final beat on the same edge: line not marked valid.

Reset
REQ-026 RESET asserted: state IDLE, all valid bits 0, beat counter 0, Miss_count 0, Mem_req 0, Mem_addr 0, tags 0, immediately and asynchronously.
REQ-027 RESET during FILL abandons the burst; Mem_req drops without waiting for Mem_ack.
REQ-028 First edge after RESET deasserts: evaluate a normal lookup (boot address misses).

Configuration
REQ-029 Macro IMEM_PREFETCH_EN compiles in a second (prefetch) line buffer and state PREFETCH.
REQ-030 With IMEM_PREFETCH_EN: after REQ-020 completes, if the prefetch buffer does not hold tag+1, the next edge enters PREFETCH and fills tag+1 by REQ-018..019 (tag wraps all-ones -> 0); completion sets prefetch valid.
REQ-031 With IMEM_PREFETCH_EN: lookup hits in either buffer (demand buffer has priority); a demand miss during PREFETCH waits for PREFETCH completion, then enters FILL; FLUSH also clears prefetch valid, with REQ-024 applied to prefetch fills; prefetch fills do not increment Miss_count.
REQ-032 Without IMEM_PREFETCH_EN: no second buffer, no PREFETCH state, no memory traffic except demand fills.

Verification
REQ-033 Reset, address 0xBFC00000, Mem_ack always 1 with rdata = word address -> STALL_2IF high 5 cycles, Mem_addr 0xBFC00000, then Instr1_2IF = 0xBFC00000, Miss_count = 1.
REQ-034 After fill, sweep 0xBFC00004..0xBFC0000C -> STALL_2IF = 0 every cycle, Instr1_2IF tracks address, Miss_count stays 1.
REQ-035 Mem_ack toggling 1,0,1,0... during fill -> 8 fill cycles, correct word order, Mem_addr stable throughout.
REQ-036 FLUSH pulse on the second fill beat -> burst completes, re-lookup misses, second fill issued, Miss_count = 2.
REQ-037 RESET pulse mid-fill -> Mem_req 0 asynchronously, Miss_count 0, no hit afterwards.
REQ-038 IMEM_PREFETCH_EN, demand 0xFFFFFFF0 -> prefetch Mem_addr 0x00000000; then address 0x00000004 hits with no stall and Miss_count 1.

Source files
------------

// File: rtl/imem_line_buffer_if.sv
// imem_line_buffer_if -- fetch and backing-memory signal bundle for the
// instruction line buffer. Signal names follow the fetch pipeline naming.
// The slave modport is the line buffer's view. The master modport is the
// view of its environment (fetch stage plus memory).
interface imem_line_buffer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Instr_address_fIF;
    logic              FLUSH;
    logic [31:0]       Instr1_2IF;
    logic              STALL_2IF;
    logic              Mem_req;
    logic [ADDR_W-1:0] Mem_addr;
    logic              Mem_ack;
    logic [31:0]       Mem_rdata;
    logic [15:0]       Miss_count;

    modport slave (
        input  Instr_address_fIF,
        input  FLUSH,
        input  Mem_ack,
        input  Mem_rdata,
        output Instr1_2IF,
        output STALL_2IF,
        output Mem_req,
        output Mem_addr,
        output Miss_count
    );

    modport master (
        output Instr_address_fIF,
        output FLUSH,
        output Mem_ack,
        output Mem_rdata,
        input  Instr1_2IF,
        input  STALL_2IF,
        input  Mem_req,
        input  Mem_addr,
        input  Miss_count
    );
endinterface

// File: rtl/imem_line_buffer.sv
// imem_line_buffer -- single-line instruction buffer in front of a slow
// burst memory. A lookup is combinational. A miss fetches a whole line with
// an ascending-word burst.
// Optional feature: define IMEM_PREFETCH_EN to add a second line buffer.
// After each demand fill completes, that buffer is filled with the next
// sequential line.
module imem_line_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    imem_line_buffer_if.slave   bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

`ifdef IMEM_PREFETCH_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_PREFETCH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1
    } state_t;
`endif

    state_t            state_r;
    state_t            state_s;

    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic              unused_addr_bits_s;

    // demand line
    logic [31:0]       d_data_r [LINE_WORDS];
    logic [TAG_W-1:0]  d_tag_r;
    logic              d_valid_r;
    logic              d_hit_s;

    // burst engine shared by every fill
    logic [TAG_W-1:0]  fill_tag_r;
    logic [IDX_W-1:0]  beat_r;
    logic              flush_seen_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       miss_count_r;

    logic              hit_s;
    logic [31:0]       instr_s;
    logic              start_fill_s;
    logic              accept_s;
    logic              last_s;
    logic              line_ok_s;

`ifdef IMEM_PREFETCH_EN
    logic [31:0]       p_data_r [LINE_WORDS];
    logic [TAG_W-1:0]  p_tag_r;
    logic              p_valid_r;
    logic              p_hit_s;
    logic              pf_pending_r;
    logic              start_pf_s;
    logic [TAG_W-1:0]  next_tag_s;
    logic              pf_holds_next_s;
`endif

    assign req_tag_s          = bus.Instr_address_fIF[ADDR_W-1:OFF_W];
    assign req_idx_s          = bus.Instr_address_fIF[OFF_W-1:2];
    assign unused_addr_bits_s = ^bus.Instr_address_fIF[1:0];

    assign d_hit_s = d_valid_r && (d_tag_r == req_tag_s);

    // A completed burst leaves a valid line only if no FLUSH arrived
    // during the burst, including on the final edge.
    assign line_ok_s = !(flush_seen_r || bus.FLUSH);

`ifdef IMEM_PREFETCH_EN
    assign p_hit_s         = p_valid_r && (p_tag_r == req_tag_s);
    assign hit_s           = d_hit_s || p_hit_s;
    assign next_tag_s      = d_tag_r + {{(TAG_W-1){1'b0}}, 1'b1};
    assign pf_holds_next_s = p_valid_r && (p_tag_r == next_tag_s);
`else
    assign hit_s = d_hit_s;
`endif

    // Lookup data: the demand line has priority; a miss returns zero
    always_comb begin
        instr_s = 32'd0;
        if (d_hit_s) begin
            instr_s = d_data_r[req_idx_s];
        end
`ifdef IMEM_PREFETCH_EN
        else if (p_hit_s) begin
            instr_s = p_data_r[req_idx_s];
        end
`endif
        else begin
            instr_s = 32'd0;
        end
    end

    assign bus.Instr1_2IF = instr_s;
    assign bus.STALL_2IF  = !hit_s;
    assign bus.Mem_req    = mem_req_r;
    assign bus.Mem_addr   = mem_addr_r;
    assign bus.Miss_count = miss_count_r;

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_s      = state_r;
        start_fill_s = 1'b0;
        accept_s     = 1'b0;
        last_s       = 1'b0;
`ifdef IMEM_PREFETCH_EN
        start_pf_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef IMEM_PREFETCH_EN
                // The next-line fetch launched by a finished demand fill
                // goes first. A demand miss seen now is retried afterwards.
                if (pf_pending_r && !bus.FLUSH && !pf_holds_next_s) begin
                    state_s    = ST_PREFETCH;
                    start_pf_s = 1'b1;
                end else if (!hit_s) begin
                    state_s      = ST_FILL;
                    start_fill_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (!hit_s) begin
                    state_s      = ST_FILL;
                    start_fill_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
            ST_FILL: begin
                if (bus.Mem_ack) begin
                    accept_s = 1'b1;
                    if (beat_r == LAST_BEAT) begin
                        last_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
`ifdef IMEM_PREFETCH_EN
            ST_PREFETCH: begin
                if (bus.Mem_ack) begin
                    accept_s = 1'b1;
                    if (beat_r == LAST_BEAT) begin
                        last_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_PREFETCH;
                    end
                end else begin
                    state_s = ST_PREFETCH;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst engine: fill address, request, beat counter, flush memory
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fill_tag_r   <= {TAG_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_req_r    <= 1'b0;
            beat_r       <= {IDX_W{1'b0}};
            flush_seen_r <= 1'b0;
        end else if (start_fill_s) begin
            fill_tag_r   <= req_tag_s;
            mem_addr_r   <= {req_tag_s, {OFF_W{1'b0}}};
            mem_req_r    <= 1'b1;
            beat_r       <= {IDX_W{1'b0}};
            flush_seen_r <= 1'b0;
        end
`ifdef IMEM_PREFETCH_EN
        else if (start_pf_s) begin
            fill_tag_r   <= next_tag_s;
            mem_addr_r   <= {next_tag_s, {OFF_W{1'b0}}};
            mem_req_r    <= 1'b1;
            beat_r       <= {IDX_W{1'b0}};
            flush_seen_r <= 1'b0;
        end
`endif
        else if (state_r != ST_IDLE) begin
            if (bus.FLUSH) begin
                flush_seen_r <= 1'b1;
            end
            if (accept_s) begin
                if (last_s) begin
                    beat_r    <= {IDX_W{1'b0}};
                    mem_req_r <= 1'b0;
                end else begin
                    beat_r <= beat_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Demand line words are written beat by beat during a demand fill
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                d_data_r[i] <= 32'd0;
            end
        end else if ((state_r == ST_FILL) && accept_s) begin
            d_data_r[beat_r] <= bus.Mem_rdata;
        end
    end

    // Demand tag/valid: cleared at fill start (words are being replaced)
    // and on FLUSH. Set on the final beat unless the fill was flushed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            d_tag_r   <= {TAG_W{1'b0}};
            d_valid_r <= 1'b0;
        end else if ((state_r == ST_FILL) && last_s) begin
            d_tag_r   <= fill_tag_r;
            d_valid_r <= line_ok_s;
        end else if (start_fill_s || bus.FLUSH) begin
            d_valid_r <= 1'b0;
        end
    end

    // Demand miss counter, wraps naturally at 16 bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            miss_count_r <= 16'd0;
        end else if (start_fill_s) begin
            miss_count_r <= miss_count_r + 16'd1;
        end
    end

`ifdef IMEM_PREFETCH_EN
    // Prefetch line words are written beat by beat during a prefetch fill
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                p_data_r[i] <= 32'd0;
            end
        end else if ((state_r == ST_PREFETCH) && accept_s) begin
            p_data_r[beat_r] <= bus.Mem_rdata;
        end
    end

    // Prefetch tag/valid, with the same flush rules as the demand line
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_tag_r   <= {TAG_W{1'b0}};
            p_valid_r <= 1'b0;
        end else if ((state_r == ST_PREFETCH) && last_s) begin
            p_tag_r   <= fill_tag_r;
            p_valid_r <= line_ok_s;
        end else if (start_pf_s || bus.FLUSH) begin
            p_valid_r <= 1'b0;
        end
    end

    // A clean demand completion requests one next-line prefetch.
    // The request is consumed by the following IDLE cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pf_pending_r <= 1'b0;
        end else if ((state_r == ST_FILL) && last_s) begin
            pf_pending_r <= line_ok_s;
        end else if (state_r == ST_IDLE) begin
            pf_pending_r <= 1'b0;
        end
    end
`endif

endmodule
